// File: rtl/micro_sequencer_if.sv
// Control bundle between the SAP microsequencer and its datapath: run/step/opcode in,
// T-state ring, one-hot-per-step control word and status out.
interface micro_sequencer_if #(
    parameter int COUNT_W = 8
) ();
    logic               run;
    logic               step;
    logic [3:0]         opcode;
    logic [5:0]         t;
    logic               ep;
    logic               cp;
    logic               lp;
    logic               lm;
    logic               epr;
    logic               li;
    logic               ei;
    logic               la;
    logic               ea;
    logic               lb;
    logic               ev;
    logic               n;
    logic               lo;
    logic               running;
    logic               halted;
    logic               illegal;
    logic [COUNT_W-1:0] instr_count;

    modport master (
        input  run, step, opcode,
        output t, ep, cp, lp, lm, epr, li, ei, la, ea, lb, ev, n, lo,
        output running, halted, illegal, instr_count
    );

    modport slave (
        output run, step, opcode,
        input  t, ep, cp, lp, lm, epr, li, ei, la, ea, lb, ev, n, lo,
        input  running, halted, illegal, instr_count
    );
endinterface

// File: rtl/micro_sequencer.sv
// Registered microsequencer for the 8-bit SAP CPU: T-state ring, Moore control-word decode,
// run/single-step control, halt, optional early instruction end and retired-instruction count.
module micro_sequencer #(
    parameter bit EARLY_END = 1'b1,
    parameter int COUNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    micro_sequencer_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HALT} state_t;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control word bit order: {ep, cp, lp, lm, epr, li, ei, la, ea, lb, ev, n, lo}
    localparam logic [12:0] C_EP  = 13'h1000;
    localparam logic [12:0] C_CP  = 13'h0800;
    localparam logic [12:0] C_LP  = 13'h0400;
    localparam logic [12:0] C_LM  = 13'h0200;
    localparam logic [12:0] C_EPR = 13'h0100;
    localparam logic [12:0] C_LI  = 13'h0080;
    localparam logic [12:0] C_EI  = 13'h0040;
    localparam logic [12:0] C_LA  = 13'h0020;
    localparam logic [12:0] C_EA  = 13'h0010;
    localparam logic [12:0] C_LB  = 13'h0008;
    localparam logic [12:0] C_EV  = 13'h0004;
    localparam logic [12:0] C_N   = 13'h0002;
    localparam logic [12:0] C_LO  = 13'h0001;

    state_t             state_q;
    logic [2:0]         step_q;
    logic [5:0]         t_q;
    logic [COUNT_W-1:0] count_q;
    logic               illegal_q;
    logic               running_q;
    logic               halted_q;
    logic               at_last;
    logic [12:0]        ctl;

    function automatic logic [2:0] last_step(input logic [3:0] op);
        case (op)
            OP_LDA:         return 3'd4;
            OP_ADD, OP_SUB: return 3'd5;
            default:        return 3'd3;
        endcase
    endfunction

    function automatic logic is_defined(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_JMP) || (op == OP_OUT) || (op == OP_HLT);
    endfunction

    // last_step() never returns below 3, so a stale opcode during fetch cannot end early
    assign at_last = EARLY_END ? (step_q == last_step(bus.opcode)) : (step_q == 3'd5);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            step_q    <= 3'd0;
            t_q       <= 6'd0;
            count_q   <= '0;
            illegal_q <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.run || bus.step) begin
                        state_q   <= S_ACTIVE;
                        step_q    <= 3'd0;
                        t_q       <= 6'b000001;
                        running_q <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (step_q == 3'd3 && !is_defined(bus.opcode))
                        illegal_q <= 1'b1;
                    if (step_q == 3'd3 && bus.opcode == OP_HLT) begin
                        state_q   <= S_HALT;
                        step_q    <= 3'd0;
                        t_q       <= 6'd0;
                        running_q <= 1'b0;
                        halted_q  <= 1'b1;
                    end else if (at_last) begin
                        count_q <= count_q + COUNT_W'(1);
                        step_q  <= 3'd0;
                        if (bus.run) begin
                            t_q <= 6'b000001;
                        end else begin
                            state_q   <= S_IDLE;
                            t_q       <= 6'd0;
                            running_q <= 1'b0;
                        end
                    end else begin
                        step_q <= step_q + 3'd1;
                        t_q    <= {t_q[4:0], 1'b0};
                    end
                end
                S_HALT: ;
                default: begin
                    state_q   <= S_IDLE;
                    t_q       <= 6'd0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ctl = '0;
        if (state_q == S_ACTIVE) begin
            case (step_q)
                3'd0: ctl = C_EP | C_LM;
                3'd1: ctl = C_CP;
                3'd2: ctl = C_EPR | C_LI;
                3'd3: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB: ctl = C_EI | C_LM;
                        OP_JMP:                 ctl = C_EI | C_LP;
                        OP_OUT:                 ctl = C_EA | C_LO;
                        default:                ctl = '0;
                    endcase
                end
                3'd4: begin
                    case (bus.opcode)
                        OP_LDA:  ctl = C_EPR | C_LA;
                        OP_ADD:  ctl = C_EPR | C_LB;
                        OP_SUB:  ctl = C_EPR | C_LB | C_N;
                        default: ctl = '0;
                    endcase
                end
                3'd5: begin
                    case (bus.opcode)
                        OP_ADD:  ctl = C_EV | C_LA;
                        OP_SUB:  ctl = C_EV | C_LA | C_N;
                        default: ctl = '0;
                    endcase
                end
                default: ctl = '0;
            endcase
        end
    end

    assign {bus.ep, bus.cp, bus.lp, bus.lm, bus.epr, bus.li, bus.ei,
            bus.la, bus.ea, bus.lb, bus.ev, bus.n, bus.lo} = ctl;
    assign bus.t           = t_q;
    assign bus.running     = running_q;
    assign bus.halted      = halted_q;
    assign bus.illegal     = illegal_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench: a small SAP datapath (PC, MAR, RAM, IR, A, B, OUT) around the sequencer,
// plus a second narrow-counter, full-length instance fed a constant undefined opcode.
module tb_micro_sequencer;
    localparam logic [12:0] C_EP  = 13'h1000;
    localparam logic [12:0] C_CP  = 13'h0800;
    localparam logic [12:0] C_LP  = 13'h0400;
    localparam logic [12:0] C_LM  = 13'h0200;
    localparam logic [12:0] C_EPR = 13'h0100;
    localparam logic [12:0] C_LI  = 13'h0080;
    localparam logic [12:0] C_EI  = 13'h0040;
    localparam logic [12:0] C_LA  = 13'h0020;
    localparam logic [12:0] C_EA  = 13'h0010;
    localparam logic [12:0] C_LB  = 13'h0008;
    localparam logic [12:0] C_EV  = 13'h0004;
    localparam logic [12:0] C_N   = 13'h0002;
    localparam logic [12:0] C_LO  = 13'h0001;

    logic clk;
    logic reset;
    logic reset2;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic bus_chk = 1'b0;

    micro_sequencer_if #(.COUNT_W(8)) sif ();
    micro_sequencer_if #(.COUNT_W(2)) sif2 ();

    micro_sequencer #(.EARLY_END(1'b1), .COUNT_W(8)) dut (
        .clk(clk), .reset(reset), .bus(sif));
    micro_sequencer #(.EARLY_END(1'b0), .COUNT_W(2)) dut2 (
        .clk(clk), .reset(reset2), .bus(sif2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model
    logic [7:0]  mem [16];
    logic [3:0]  pc, mar;
    logic [7:0]  ir, a, b, outr, w;
    logic        dp_clr;
    logic [12:0] ctl, ctl2;

    assign ctl  = {sif.ep, sif.cp, sif.lp, sif.lm, sif.epr, sif.li, sif.ei,
                   sif.la, sif.ea, sif.lb, sif.ev, sif.n, sif.lo};
    assign ctl2 = {sif2.ep, sif2.cp, sif2.lp, sif2.lm, sif2.epr, sif2.li, sif2.ei,
                   sif2.la, sif2.ea, sif2.lb, sif2.ev, sif2.n, sif2.lo};
    assign sif.opcode  = ir[7:4];
    assign sif2.opcode = 4'b0100;

    always_comb begin
        w = 8'h00;
        if (sif.ep)       w = {4'h0, pc};
        else if (sif.epr) w = mem[mar];
        else if (sif.ei)  w = {4'h0, ir[3:0]};
        else if (sif.ea)  w = a;
        else if (sif.ev)  w = sif.n ? (a - b) : (a + b);
    end

    always @(posedge clk) begin
        if (dp_clr) begin
            pc <= 4'h0;
            ir <= 8'h00;
        end else begin
            if (sif.lp)      pc <= w[3:0];
            else if (sif.cp) pc <= pc + 4'h1;
            if (sif.li)      ir <= w;
        end
        if (sif.lm) mar  <= w[3:0];
        if (sif.la) a    <= w;
        if (sif.lb) b    <= w;
        if (sif.lo) outr <= w;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus_chk) begin
            check_eq("w_drivers", 32'($countones({sif.ep, sif.epr, sif.ei, sif.ea, sif.ev}) <= 1), 32'd1);
            check_eq("w_drivers2", 32'($countones({sif2.ep, sif2.epr, sif2.ei, sif2.ea, sif2.ev}) <= 1), 32'd1);
        end
    end

    task automatic cyc(input string tag, input int s, input logic [12:0] exp_ctl);
        logic [5:0] et;
        et = 6'b000001 << s;
        @(negedge clk);
        check_eq({tag, "_t"}, 32'(sif.t), 32'(et));
        check_eq({tag, "_ctl"}, 32'(ctl), 32'(exp_ctl));
    endtask

    task automatic fetch(input string tag);
        cyc({tag, "_T0"}, 0, C_EP | C_LM);
        cyc({tag, "_T1"}, 1, C_CP);
        cyc({tag, "_T2"}, 2, C_EPR | C_LI);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        dp_clr   = 1'b1;
        sif.run  = 1'b0;
        sif.step = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        dp_clr = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        reset2    = 1'b1;
        dp_clr    = 1'b1;
        sif.run   = 1'b0;
        sif.step  = 1'b0;
        sif2.run  = 1'b0;
        sif2.step = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // Reset state, then LDA 9; OUT; HLT
        do_reset();
        bus_chk = 1'b1;
        check_eq("rst_t", 32'(sif.t), 32'd0);
        check_eq("rst_ctl", 32'(ctl), 32'd0);
        check_eq("rst_running", 32'(sif.running), 32'd0);
        check_eq("rst_halted", 32'(sif.halted), 32'd0);
        check_eq("rst_illegal", 32'(sif.illegal), 32'd0);
        check_eq("rst_count", 32'(sif.instr_count), 32'd0);
        mem[0] = 8'h09; mem[1] = 8'hE0; mem[2] = 8'hF0; mem[9] = 8'h1C;
        sif.run = 1'b1;
        fetch("lda");
        cyc("lda_T3", 3, C_EI | C_LM);
        cyc("lda_T4", 4, C_EPR | C_LA);
        fetch("out");
        cyc("out_T3", 3, C_EA | C_LO);
        fetch("hlt");
        cyc("hlt_T3", 3, 13'h0000);
        @(negedge clk);
        check_eq("p1_halted", 32'(sif.halted), 32'd1);
        check_eq("p1_running", 32'(sif.running), 32'd0);
        check_eq("p1_t", 32'(sif.t), 32'd0);
        check_eq("p1_count", 32'(sif.instr_count), 32'd2);
        check_eq("p1_outr", 32'(outr), 32'h1C);
        sif.step = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("halt_hold", 32'(sif.halted), 32'd1);
        check_eq("halt_t", 32'(sif.t), 32'd0);
        check_eq("halt_ctl", 32'(ctl), 32'd0);
        do_reset();
        check_eq("halt_rst", 32'(sif.halted), 32'd0);

        // ADD 10; SUB 11; JMP 0, early end: 6/6/4 cycles
        mem[0] = 8'h1A; mem[1] = 8'h2B; mem[2] = 8'h30; mem[10] = 8'h05; mem[11] = 8'h03;
        sif.run = 1'b1;
        fetch("add");
        cyc("add_T3", 3, C_EI | C_LM);
        cyc("add_T4", 4, C_EPR | C_LB);
        cyc("add_T5", 5, C_EV | C_LA);
        fetch("sub");
        check_eq("add_a", 32'(a), 32'h21);
        cyc("sub_T3", 3, C_EI | C_LM);
        cyc("sub_T4", 4, C_EPR | C_LB | C_N);
        cyc("sub_T5", 5, C_EV | C_LA | C_N);
        fetch("jmp");
        check_eq("sub_a", 32'(a), 32'h1E);
        cyc("jmp_T3", 3, C_EI | C_LP);
        cyc("jmp_next_T0", 0, C_EP | C_LM);
        check_eq("jmp_pc", 32'(pc), 32'd0);
        check_eq("p2_count", 32'(sif.instr_count), 32'd3);
        sif.run = 1'b0;
        cyc("add2_T1", 1, C_CP);
        cyc("add2_T2", 2, C_EPR | C_LI);
        cyc("add2_T3", 3, C_EI | C_LM);
        cyc("add2_T4", 4, C_EPR | C_LB);
        cyc("add2_T5", 5, C_EV | C_LA);
        @(negedge clk);
        check_eq("runfall_t", 32'(sif.t), 32'd0);
        check_eq("runfall_running", 32'(sif.running), 32'd0);
        check_eq("runfall_count", 32'(sif.instr_count), 32'd4);
        check_eq("runfall_a", 32'(a), 32'h23);

        // Single step: one LDA 10, a mid-instruction pulse is ignored
        do_reset();
        mem[0] = 8'h0A;
        sif.step = 1'b1;
        cyc("st_T0", 0, C_EP | C_LM);
        sif.step = 1'b0;
        cyc("st_T1", 1, C_CP);
        sif.step = 1'b1;
        cyc("st_T2", 2, C_EPR | C_LI);
        sif.step = 1'b0;
        cyc("st_T3", 3, C_EI | C_LM);
        cyc("st_T4", 4, C_EPR | C_LA);
        @(negedge clk);
        check_eq("st_t", 32'(sif.t), 32'd0);
        check_eq("st_running", 32'(sif.running), 32'd0);
        check_eq("st_count", 32'(sif.instr_count), 32'd1);
        check_eq("st_a", 32'(a), 32'h05);
        @(negedge clk);
        check_eq("st_noqueue", 32'(sif.t), 32'd0);

        // Undefined opcode 0101 then OUT
        do_reset();
        mem[0] = 8'h50; mem[1] = 8'hE0;
        sif.run = 1'b1;
        fetch("ill");
        cyc("ill_T3", 3, 13'h0000);
        check_eq("ill_pre", 32'(sif.illegal), 32'd0);
        cyc("ill_next_T0", 0, C_EP | C_LM);
        check_eq("ill_set", 32'(sif.illegal), 32'd1);
        sif.run = 1'b0;
        cyc("ill_next_T1", 1, C_CP);
        cyc("ill_next_T2", 2, C_EPR | C_LI);
        cyc("ill_out_T3", 3, C_EA | C_LO);
        @(negedge clk);
        check_eq("ill_sticky", 32'(sif.illegal), 32'd1);
        check_eq("ill_count", 32'(sif.instr_count), 32'd2);
        check_eq("ill_outr", 32'(outr), 32'h05);

        // Reset during T4 of ADD
        do_reset();
        mem[0] = 8'hE0; mem[1] = 8'h1A;
        sif.run = 1'b1;
        fetch("r_out");
        cyc("r_out_T3", 3, C_EA | C_LO);
        fetch("r_add");
        cyc("r_add_T3", 3, C_EI | C_LM);
        cyc("r_add_T4", 4, C_EPR | C_LB);
        check_eq("r_pre_count", 32'(sif.instr_count), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("r_t", 32'(sif.t), 32'd0);
        check_eq("r_ctl", 32'(ctl), 32'd0);
        check_eq("r_running", 32'(sif.running), 32'd0);
        check_eq("r_count", 32'(sif.instr_count), 32'd0);
        check_eq("r_a", 32'(a), 32'h05);
        reset   = 1'b0;
        sif.run = 1'b0;
        @(negedge clk);
        check_eq("r_idle", 32'(sif.t), 32'd0);

        // Narrow counter, full-length NOP-class instructions
        reset2 = 1'b0;
        sif2.run = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            for (int s = 0; s < 6; s++) begin
                @(negedge clk);
                check_eq("nop_t", 32'(sif2.t), 32'(6'b000001 << s));
                if (s >= 3) check_eq("nop_ctl", 32'(ctl2), 32'd0);
                if (s == 0 && k >= 2) check_eq("nop_count", 32'(sif2.instr_count), 32'(k - 1));
            end
        end
        sif2.run = 1'b0;
        @(negedge clk);
        check_eq("nop_wrap", 32'(sif2.instr_count), 32'd0);
        check_eq("nop_illegal", 32'(sif2.illegal), 32'd1);
        check_eq("nop_stop", 32'(sif2.running), 32'd0);

        bus_chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Replaces the free-running beat ring counter and the hard-wired control_unit with one registered microsequencer for the 8-bit SAP-style CPU.
- Generates the T-state ring and the one-hot-per-step control word that drives pc, store_unit, ir, register_group and output_unit on the shared 8-bit W bus.
- Adds run/single-step control, a halt state, optional early instruction termination and a retired-instruction counter.

Parameters:
- EARLY_END, 1: 1 = jump to T0 after an opcode's last active microstep; 0 = always run T0..T5.
- COUNT_W, 8: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- run  in  1  level: 1 = execute continuously
- step  in  1  single-cycle pulse, honoured only in IDLE with run=0: execute exactly one instruction
- opcode  in  4  ir operate_code, valid from T3
- t  out  6  one-hot T-state, t[0]=T0; all zero outside FETCH/EXEC
- ep  out  1  PC drives W bus
- cp  out  1  PC increment
- lp  out  1  PC loads from W[3:0]
- lm  out  1  MAR loads from W[3:0]
- epr  out  1  RAM drives W bus
- li  out  1  IR loads from W bus
- ei  out  1  IR operand drives W[3:0]
- la  out  1  A loads from W bus
- ea  out  1  A drives W bus
- lb  out  1  B loads from W bus
- ev  out  1  ALU result drives W bus
- n  out  1  ALU subtract select
- lo  out  1  output register loads
- running  out  1  high in FETCH/EXEC
- halted  out  1  high in HALT
- illegal  out  1  sticky; set when an undefined opcode reaches T3
- instr_count  out  COUNT_W  retired instructions, wraps

Behaviour:
- States: IDLE, ACTIVE (step index 0..5), HALT.
- Control outputs are Moore decode of state, step index and opcode.
- At most one W-bus driver (ep, epr, ei, ea, ev) is high in any cycle.
- Reset: state=IDLE; t=0; all control outputs 0; running=0, halted=0, illegal=0, instr_count=0. Reset has priority over every other input, including mid-instruction and in HALT.
- IDLE -> T0 when run=1, or when step=1. IDLE is never left on the same edge as reset.
- Fetch, all opcodes:
  - T0: ep, lm
  - T1: cp
  - T2: epr, li
- Execute:
  - LDA 0000: T3 ei,lm; T4 epr,la; T5 none
  - ADD 0001: T3 ei,lm; T4 epr,lb; T5 ev,la
  - SUB 0010: as ADD, with n=1 in T4 and T5
  - JMP 0011: T3 ei,lp
  - OUT 1110: T3 ea,lo
  - HLT 1111: T3 no controls; next state HALT
  - Any other opcode: no controls; illegal<=1 at end of T3; executes as NOP.
- Last active step: LDA=T4, ADD/SUB=T5, JMP/OUT/NOP=T3.
  - EARLY_END=1: next state after the last active step is the boundary.
  - EARLY_END=0: next state after T5 is the boundary.
- Boundary handling:
  - instr_count increments by 1, wrapping all-ones -> 0.
  - run=1: go to T0.
  - run=0: go to IDLE.
- run falling mid-instruction: the current instruction completes; stop at the boundary.
- step pulse while ACTIVE or HALT: ignored, not queued.
- HLT: instr_count is not incremented. HALT is exited only by reset; run and step are ignored there.
- Latency:
  - run=1 sampled in IDLE -> T0 visible next cycle.
  - ADD occupies 6 cycles.
  - LDA occupies 5 cycles with EARLY_END=1.

Test Plan:
- Reset, then run=1 with RAM program LDA 9; OUT; HLT (mem[9]=0x1C) -> control sequence exactly as tabulated; output register=0x1C; halted=1 after 3 fetches; instr_count=2.
- EARLY_END=1, program ADD/SUB/JMP -> cycle counts per instruction 6/6/4.
  - n high only in SUB T4-T5.
  - After JMP to 0, next T0 has PC=0.
- run=0 with one step pulse -> exactly one instruction runs, then running=0 and t=0. A second step pulse given mid-instruction changes nothing.
- Opcode 0101 -> illegal=1 at end of T3 and stays set; no control asserted in T3-T5; next fetch proceeds normally.
- Assert reset during T4 of ADD -> next cycle IDLE, all outputs 0, instr_count=0, A unchanged by la.
- COUNT_W=2, run four NOP-class instructions -> instr_count 1,2,3,0. Every cycle the bus-driver checker sees at most one driver.
